lfsr16_checker: RTL



---
 rtl/lfsr16_checker.sv | 139 +++++++++++++
 1 files changed

// File: rtl/lfsr16_checker.sv
// Receive-side checker for the 16-bit Fibonacci LFSR (mask 16'hD008, shift-left).
// It synchronises to the incoming word stream, then flags every word that differs from the predicted next state.
module lfsr16_checker #(
    parameter int LOCK_COUNT   = 4,
    parameter int UNLOCK_COUNT = 3,
    parameter int ERR_W        = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    input  logic [15:0]      data_i,
    input  logic             clear_i,
    output logic             locked_o,
    output logic             error_o,
    output logic [ERR_W-1:0] err_count_o
);

    localparam int MW = $clog2(LOCK_COUNT + 1);
    localparam int UW = $clog2(UNLOCK_COUNT + 1);
    localparam logic [MW-1:0]    LOCK_TGT   = MW'(LOCK_COUNT);
    localparam logic [UW-1:0]    UNLOCK_TGT = UW'(UNLOCK_COUNT);
    localparam logic [ERR_W-1:0] ERR_MAX    = {ERR_W{1'b1}};

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    function automatic logic [15:0] lfsr_next(input logic [15:0] x);
        return {x[14:0], ^(x & 16'hD008)};
    endfunction

    state_t           state_r, state_next_s;
    logic [15:0]      expect_r, expect_next_s;
    logic [MW-1:0]    match_run_r, match_run_next_s;
    logic [UW-1:0]    miss_run_r, miss_run_next_s;
    logic [ERR_W-1:0] err_count_r, err_count_next_s;
    logic             locked_r, locked_next_s;
    logic             error_r, error_next_s;
    logic             miss_hit_s;

    // State and registered outputs; reset is synchronous
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r     <= HUNT;
            expect_r    <= 16'd0;
            match_run_r <= {MW{1'b0}};
            miss_run_r  <= {UW{1'b0}};
            err_count_r <= {ERR_W{1'b0}};
            locked_r    <= 1'b0;
            error_r     <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            expect_r    <= expect_next_s;
            match_run_r <= match_run_next_s;
            miss_run_r  <= miss_run_next_s;
            err_count_r <= err_count_next_s;
            locked_r    <= locked_next_s;
            error_r     <= error_next_s;
        end
    end

    // Next-state and prediction logic
    always_comb begin
        state_next_s     = state_r;
        expect_next_s    = expect_r;
        match_run_next_s = match_run_r;
        miss_run_next_s  = miss_run_r;
        miss_hit_s       = 1'b0;
        if (valid_i) begin
            case (state_r)
                HUNT: begin
                    if (data_i != 16'd0) begin
                        expect_next_s    = lfsr_next(data_i);
                        match_run_next_s = {MW{1'b0}};
                        state_next_s     = SYNC;
                    end else begin
                        state_next_s = HUNT;
                    end
                end
                SYNC: begin
                    if (data_i == expect_r) begin
                        expect_next_s    = lfsr_next(data_i);
                        match_run_next_s = match_run_r + MW'(32'd1);
                        if ((match_run_r + MW'(32'd1)) == LOCK_TGT) begin
                            state_next_s = LOCKED;
                        end else begin
                            state_next_s = SYNC;
                        end
                    end else if (data_i != 16'd0) begin
                        expect_next_s    = lfsr_next(data_i);
                        match_run_next_s = {MW{1'b0}};
                    end else begin
                        state_next_s = HUNT;
                    end
                end
                LOCKED: begin
                    // Freewheel on our own prediction so one bad word cannot derail us
                    expect_next_s = lfsr_next(expect_r);
                    if (data_i == expect_r) begin
                        miss_run_next_s = {UW{1'b0}};
                    end else begin
                        miss_hit_s = 1'b1;
                        if ((miss_run_r + UW'(32'd1)) == UNLOCK_TGT) begin
                            miss_run_next_s = {UW{1'b0}};
                            state_next_s    = HUNT;
                        end else begin
                            miss_run_next_s = miss_run_r + UW'(32'd1);
                        end
                    end
                end
                default: begin
                    state_next_s = HUNT;
                end
            endcase
        end else begin
            state_next_s = state_r;
        end
    end

    // Output and error-counter next values
    always_comb begin
        locked_next_s = (state_next_s == LOCKED);
        error_next_s  = miss_hit_s;
        if (clear_i) begin
            err_count_next_s = {ERR_W{1'b0}};
        end else if (miss_hit_s && (err_count_r != ERR_MAX)) begin
            err_count_next_s = err_count_r + ERR_W'(32'd1);
        end else begin
            err_count_next_s = err_count_r;
        end
    end

    assign locked_o    = locked_r;
    assign error_o     = error_r;
    assign err_count_o = err_count_r;

endmodule
